// File: rtl/bus_responder.sv
// -----------------------------------------------------------------------------
// bus_responder
//
// Single-port CPU bus slave. Each request is captured in IDLE, optionally held
// for a number of wait states, and answered with a one-cycle ready pulse
// carrying read data and an unmapped-access flag.
//
// Address map:
//   0x0000 .. 2^RAM_AW-1   byte RAM (contents not reset)
//   IO_BASE+0              LED register (read/write)
//   IO_BASE+1              cycle counter low byte; the read latches the high byte
//   IO_BASE+2              latched counter high byte
//   IO_BASE+3              status {7'b0, waits_compiled_in}
//   anything else          unmapped: err=1, read data 0x00, writes discarded
//
// Build option:
//   BUS_RESPONDER_WAITSTATE_EN  defined -> WAIT_CYCLES wait states per access
//                               undefined -> IDLE goes straight to RESP
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   req      access request
//   rw       1 = read, 0 = write
//   addr     16-bit access address
//   wdata    write data
//   rdata    read data, valid while ready=1, else 0x00
//   ready    one-cycle access-complete pulse
//   err      unmapped-access flag, valid while ready=1
//   led_out  LED register contents
// -----------------------------------------------------------------------------
module bus_responder #(
    parameter int          RAM_AW      = 10,
    parameter logic [15:0] IO_BASE     = 16'hD000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        err,
    output logic [7:0]  led_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

`ifdef BUS_RESPONDER_WAITSTATE_EN
    localparam logic           WAITS_EN  = 1'b1;
    localparam int             WCW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYCLES - 1);
    localparam logic [WCW-1:0] WCNT_ZERO = {WCW{1'b0}};
    localparam logic [WCW-1:0] WCNT_ONE  = WCW'(1);
    logic [WCW-1:0] wait_cnt_r;
`else
    localparam logic WAITS_EN = 1'b0;
    logic unused_s;
    assign unused_s = |WAIT_CYCLES;
`endif

    localparam logic [7:0] STATUS_BYTE = {7'b0000000, WAITS_EN};

    state_t       state_r;
    state_t       state_next_s;
    logic [15:0]  addr_r;
    logic         rw_r;
    logic [7:0]   wdata_r;
    logic [15:0]  op_addr_s;
    logic         op_rw_s;
    logic [7:0]   op_wdata_s;
    logic         accept_s;
    logic         commit_s;
    logic         sel_ram_s;
    logic         sel_io_s;
    logic [15:0]  io_off_s;
    logic [1:0]   io_idx_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic [7:0]   mem_r [2**RAM_AW];
    logic [15:0]  cnt_r;
    logic [7:0]   shadow_r;
    logic [7:0]   led_r;
    logic [7:0]   rdata_r;
    logic         ready_r;
    logic         err_r;
    logic [7:0]   rdata_next_s;
    logic         ready_next_s;
    logic         err_next_s;
    logic         ram_we_s;
    logic         led_we_s;
    logic         shadow_we_s;

    assign accept_s = (state_r == ST_IDLE) && req;

    // Without wait states the access completes on the accept edge itself, so
    // the live bus is used in IDLE and the captured copy afterwards.
    assign op_addr_s  = (state_r == ST_IDLE) ? addr  : addr_r;
    assign op_rw_s    = (state_r == ST_IDLE) ? rw    : rw_r;
    assign op_wdata_s = (state_r == ST_IDLE) ? wdata : wdata_r;

    // An access must never commit on an edge where reset is held.
    assign commit_s = (state_next_s == ST_RESP) && !rst;

    assign sel_ram_s = ((op_addr_s >> RAM_AW) == 16'h0000);
    assign io_off_s  = op_addr_s - IO_BASE;
    assign sel_io_s  = (io_off_s < 16'd4);
    assign io_idx_s  = io_off_s[1:0];
    assign ram_idx_s = op_addr_s[RAM_AW-1:0];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
`ifdef BUS_RESPONDER_WAITSTATE_EN
                    if (WAIT_CYCLES > 0) begin
                        state_next_s = ST_WAIT;
                    end else begin
                        state_next_s = ST_RESP;
                    end
`else
                    state_next_s = ST_RESP;
`endif
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
`ifdef BUS_RESPONDER_WAITSTATE_EN
                if (wait_cnt_r == WCNT_ZERO) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
`else
                state_next_s = ST_IDLE;
`endif
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

`ifdef BUS_RESPONDER_WAITSTATE_EN
    // Wait-state down-counter: loaded on accept, WAIT ends when it reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= WCNT_ZERO;
        end else if (accept_s) begin
            wait_cnt_r <= WAIT_LOAD;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != WCNT_ZERO)) begin
            wait_cnt_r <= wait_cnt_r - WCNT_ONE;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end
`endif

    // Capture the access operands on the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r  <= 16'h0000;
            rw_r    <= 1'b0;
            wdata_r <= 8'h00;
        end else if (accept_s) begin
            addr_r  <= addr;
            rw_r    <= rw;
            wdata_r <= wdata;
        end else begin
            addr_r  <= addr_r;
            rw_r    <= rw_r;
            wdata_r <= wdata_r;
        end
    end

    // FSM output logic: response values and write strobes for the RESP edge
    always_comb begin
        ready_next_s = 1'b0;
        rdata_next_s = 8'h00;
        err_next_s   = 1'b0;
        ram_we_s     = 1'b0;
        led_we_s     = 1'b0;
        shadow_we_s  = 1'b0;
        if (commit_s) begin
            ready_next_s = 1'b1;
            if (sel_ram_s) begin
                if (op_rw_s) begin
                    rdata_next_s = mem_r[ram_idx_s];
                end else begin
                    ram_we_s = 1'b1;
                end
            end else if (sel_io_s) begin
                case (io_idx_s)
                    2'd0: begin
                        if (op_rw_s) begin
                            rdata_next_s = led_r;
                        end else begin
                            led_we_s = 1'b1;
                        end
                    end
                    2'd1: begin
                        if (op_rw_s) begin
                            rdata_next_s = cnt_r[7:0];
                            shadow_we_s  = 1'b1;
                        end else begin
                            rdata_next_s = 8'h00;
                        end
                    end
                    2'd2: begin
                        if (op_rw_s) begin
                            rdata_next_s = shadow_r;
                        end else begin
                            rdata_next_s = 8'h00;
                        end
                    end
                    2'd3: begin
                        if (op_rw_s) begin
                            rdata_next_s = STATUS_BYTE;
                        end else begin
                            rdata_next_s = 8'h00;
                        end
                    end
                    default: rdata_next_s = 8'h00;
                endcase
            end else begin
                err_next_s = 1'b1;
            end
        end else begin
            ready_next_s = 1'b0;
        end
    end

    // Response output registers: non-zero only during the RESP cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r <= 1'b0;
            rdata_r <= 8'h00;
            err_r   <= 1'b0;
        end else begin
            ready_r <= ready_next_s;
            rdata_r <= rdata_next_s;
            err_r   <= err_next_s;
        end
    end

    // Free-running cycle counter, LED register and counter high-byte shadow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= 16'h0000;
            led_r    <= 8'h00;
            shadow_r <= 8'h00;
        end else begin
            cnt_r    <= cnt_r + 16'h0001;
            led_r    <= led_we_s ? op_wdata_s : led_r;
            shadow_r <= shadow_we_s ? cnt_r[15:8] : shadow_r;
        end
    end

    // Byte RAM: written on the edge entering RESP, contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[ram_idx_s] <= op_wdata_s;
        end
    end

    assign rdata   = rdata_r;
    assign ready   = ready_r;
    assign err     = err_r;
    assign led_out = led_r;

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter RAM_AW, default 10, sets the RAM address width; RAM size is 2^RAM_AW bytes and starts at 0x0000.
REQ-002 Parameter IO_BASE, default 16'hD000, sets the base address of the 4-byte register window.
REQ-003 Parameter WAIT_CYCLES, default 2, sets the number of wait states inserted per access when waits are compiled in.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port req, input, 1 bit: access request from the CPU.
REQ-007 Port rw, input, 1 bit: access direction; 1 = read, 0 = write.
REQ-008 Port addr, input, 16 bits: access address, {high byte, low byte}.
REQ-009 Port wdata, input, 8 bits: write data.
REQ-010 Port rdata, output, 8 bits: read data; valid only while ready=1.
REQ-011 Port ready, output, 1 bit: one-cycle access-complete pulse.
REQ-012 Port err, output, 1 bit: unmapped-access flag; valid only while ready=1.
REQ-013 Port led_out, output, 8 bits: LED register contents.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 In IDLE with req=1, the block SHALL capture addr, rw and wdata, then go to WAIT; if WAIT_CYCLES=0 it SHALL go directly to RESP.
REQ-016 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by an internal down-counter, then go to RESP.
REQ-017 RESP SHALL last one cycle with ready=1, then return to IDLE; ready=0 in all other states.
REQ-018 req SHALL be ignored in WAIT and RESP; the earliest next accept is the first IDLE cycle after RESP, so back-to-back accesses are spaced by one idle cycle.
REQ-019 Only captured values SHALL be used; changes on addr, rw or wdata after the accept cycle have no effect.
REQ-020 Address decode: addr < 2^RAM_AW selects RAM; IO_BASE..IO_BASE+3 selects registers; every other address is unmapped.
REQ-021 RAM read: rdata = mem[addr] during RESP.
REQ-022 RAM write: the write SHALL commit on the edge that enters RESP.
REQ-023 IO_BASE+0 is the LED register (read/write); a write updates led_out on the edge entering RESP.
REQ-024 IO_BASE+1 SHALL read the low byte of a free-running 16-bit cycle counter; the same read SHALL latch the high byte into a shadow register.
REQ-025 IO_BASE+2 SHALL read the shadow register.
REQ-026 The cycle counter SHALL increment every cycle outside reset and wrap 0xFFFF to 0x0000.
REQ-027 IO_BASE+3 SHALL read the status byte {7'b0, waits_compiled_in}.
REQ-028 Writes to IO_BASE+1..+3 SHALL be discarded with err=0.
REQ-029 Unmapped read: rdata=0x00 and err=1 in RESP. Unmapped write: discarded, err=1 in RESP.
REQ-030 In IDLE and WAIT, rdata SHALL be 0x00 and err=0.

Reset
REQ-031 When rst is asserted: state=IDLE, ready=0, err=0, rdata=0x00, led_out=0x00, counter=0, shadow=0, wait counter=0.
REQ-032 RAM contents SHALL NOT be initialised by reset.
REQ-033 Reset in WAIT SHALL abandon the access: no RAM or LED write commits and no ready pulse is produced.
REQ-034 After rst deasserts, the first accept SHALL be possible on the next rising edge.

Configuration
REQ-035 Macro BUS_RESPONDER_WAITSTATE_EN defined: WAIT state and counter present; accept-to-ready latency is WAIT_CYCLES+1 cycles; status bit0=1.
REQ-036 Macro BUS_RESPONDER_WAITSTATE_EN undefined: WAIT_CYCLES is ignored, IDLE goes directly to RESP, latency is 1 cycle, and status bit0=0.

Verification
REQ-037 With waits enabled and WAIT_CYCLES=2: write 0x5A to 0x0010, then read 0x0010 -> ready 3 cycles after each accept, rdata=0x5A, err=0.
REQ-038 Write 0xA5 to 0xD000 -> led_out=0xA5 from the edge entering RESP; a following read of 0xD000 returns 0xA5.
REQ-039 Force counter=0x12FF, read 0xD001, then read 0xD002 -> first returns the low byte at sample, second returns 0x12 even though the counter has advanced; 0xFFFF wraps to 0x0000.
REQ-040 Read 0x8000 -> rdata=0x00, err=1 for one cycle; write 0x8000 -> err=1 and no RAM or LED change.
REQ-041 Assert rst during WAIT of a write of 0x77 to 0xD000 -> led_out=0x00, no ready pulse, and a subsequent access completes normally.
REQ-042 With waits disabled: read 0xD003 -> ready 1 cycle after accept, rdata=0x00; req held high throughout -> accepts spaced 2 cycles apart.
